// File: rtl/bypass_history_buffer.sv
// Byte-granular writeback bypass with a DEPTH-group history ring and a registered, one-cycle forwarding path.
// Optional statistics counter on hit_count is built when BYPASS_STATS_EN is defined.
module bypass_history_buffer #(
    parameter int NUM_PROSPECTS = 4,
    parameter int NUM_OPERANDS  = 4,
    parameter int DEPTH         = 4,
    parameter int TAG_WIDTH     = 16
) (
    input  logic                                 clk,
    input  logic                                 clr,
    input  logic [NUM_PROSPECTS-1:0]             wb_valid,
    input  logic [NUM_PROSPECTS*64-1:0]          wb_data,
    input  logic [NUM_PROSPECTS*8*TAG_WIDTH-1:0] wb_tag,
    input  logic                                 op_valid,
    input  logic [NUM_OPERANDS*64-1:0]           op_data,
    input  logic [NUM_OPERANDS*8*TAG_WIDTH-1:0]  op_tag,
    input  logic                                 stall,
    input  logic                                 flush,
    output logic                                 out_valid,
    output logic [NUM_OPERANDS*64-1:0]           out_data,
    output logic [NUM_OPERANDS-1:0]              out_modify,
    output logic [15:0]                          hit_count
);
    localparam int PW  = $clog2(DEPTH);
    localparam int GW  = NUM_PROSPECTS * 64;
    localparam int GTW = NUM_PROSPECTS * 8 * TAG_WIDTH;

    logic [GW-1:0]            hist_data  [DEPTH];
    logic [GTW-1:0]           hist_tag   [DEPTH];
    logic [NUM_PROSPECTS-1:0] hist_valid [DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            wr_slot;
    logic                     wb_any;
    logic [NUM_OPERANDS*64-1:0] fwd_data;
    logic [NUM_OPERANDS-1:0]    fwd_modify;

    assign wb_any  = |wb_valid;
    // A write in the flush cycle starts the freshly emptied ring at slot 0.
    assign wr_slot = flush ? '0 : wr_ptr;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int d = 0; d < DEPTH; d++) hist_valid[d] <= '0;
            wr_ptr <= '0;
        end else begin
            if (flush) begin
                for (int d = 0; d < DEPTH; d++) hist_valid[d] <= '0;
                wr_ptr <= '0;
            end
            if (wb_any) begin
                hist_valid[wr_slot] <= wb_valid;
                wr_ptr              <= wr_slot + 1'b1;
            end
        end
    end

    // Payload needs no reset: the valid bits alone decide whether a slot can match.
    always_ff @(posedge clk) begin
        if (wb_any) begin
            hist_data[wr_slot] <= wb_data;
            hist_tag[wr_slot]  <= wb_tag;
        end
    end

    // Candidates are scanned oldest to youngest so the last match written is the youngest one.
    always_comb begin
        fwd_data   = op_data;
        fwd_modify = '0;
        for (int n = 0; n < NUM_OPERANDS; n++) begin
            for (int i = 0; i < 8; i++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    for (int p = 0; p < NUM_PROSPECTS; p++) begin
                        for (int j = 0; j < 8; j++) begin
                            if (!flush && hist_valid[wr_ptr + PW'(k)][p] &&
                                hist_tag[wr_ptr + PW'(k)][(p*8+j)*TAG_WIDTH +: TAG_WIDTH] ==
                                op_tag[(n*8+i)*TAG_WIDTH +: TAG_WIDTH]) begin
                                fwd_data[(n*8+i)*8 +: 8] = hist_data[wr_ptr + PW'(k)][(p*8+j)*8 +: 8];
                                fwd_modify[n]            = 1'b1;
                            end
                        end
                    end
                end
                for (int p = 0; p < NUM_PROSPECTS; p++) begin
                    for (int j = 0; j < 8; j++) begin
                        if (wb_valid[p] &&
                            wb_tag[(p*8+j)*TAG_WIDTH +: TAG_WIDTH] ==
                            op_tag[(n*8+i)*TAG_WIDTH +: TAG_WIDTH]) begin
                            fwd_data[(n*8+i)*8 +: 8] = wb_data[(p*8+j)*8 +: 8];
                            fwd_modify[n]            = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_modify <= '0;
        end else begin
            if (!stall) begin
                out_valid  <= op_valid;
                out_data   <= fwd_data;
                out_modify <= fwd_modify;
            end
            if (flush) out_valid <= 1'b0;
        end
    end

`ifdef BYPASS_STATS_EN
    logic [15:0] hit_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hit_q <= '0;
        end else if (flush) begin
            hit_q <= '0;
        end else if (!stall && op_valid && (|fwd_modify) && hit_q != 16'hFFFF) begin
            hit_q <= hit_q + 16'd1;
        end
    end

    assign hit_count = hit_q;
`else
    assign hit_count = '0;
`endif

endmodule
